// File: rtl/uart_autobaud.sv
// -----------------------------------------------------------------------------
// uart_autobaud
//
// Auto-baud controller. On request, it measures one 0x55 calibration character
// (8N1) on the raw rx line and derives the clock divisor for the downstream
// baud tick generator. The divisor keeps its reset default until a measurement
// succeeds. A rejected measurement leaves the divisor and the lock flag as they
// were.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   rx       in   raw serial line (asynchronous to clk)
//   start    in   one-cycle measurement request (ignored unless idle)
//   div      out  current divisor (DIV_W bits)
//   half_div out  div >> 1
//   busy     out  measurement in progress
//   locked   out  div came from a successful measurement
//   done     out  one-cycle pulse when div updates
//   err      out  one-cycle pulse when a measurement is rejected
//
// Optional feature macro: UART_AUTOBAUD_TOL_CHECK_EN
//   When defined, every segment after the start bit must be within L0/4 of the
//   start-bit length L0. Any violation rejects the measurement.
//
// State table:
//   S_IDLE       | waiting for start
//   S_ARM        | counting IDLE_CYC consecutive high cycles on rx
//   S_WAIT_START | waiting for the falling edge of the start bit
//   S_MEASURE    | timing segments up to falling edge #5 (8 bit times)
//   S_STOP       | waiting for the rising edge into the stop bit
//   S_DONE       | divisor loaded, done pulse
//   S_ERR        | measurement rejected, err pulse
// -----------------------------------------------------------------------------
module uart_autobaud #(
    parameter int DIV_W    = 16,
    parameter int DEF_DIV  = 434,
    parameter int MIN_DIV  = 16,
    parameter int MAX_DIV  = 65535,
    parameter int IDLE_CYC = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx,
    input  logic             start,
    output logic [DIV_W-1:0] div,
    output logic [DIV_W-1:0] half_div,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             err
);

    localparam int CW = DIV_W + 4;
    localparam int IW = $clog2(IDLE_CYC + 1);
    localparam logic [CW-1:0] SEG_LIM   = CW'(2 * MAX_DIV);
    localparam logic [CW-1:0] T_LIM     = CW'(8 * MAX_DIV);
    localparam logic [CW-1:0] MIN_C     = CW'(MIN_DIV);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_START,
        S_MEASURE,
        S_STOP,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_nx;

    logic rx_s1, rx_sync, rx_prev;
    logic fall_q, rise_q, edge_q;

    logic [IW-1:0]    idle_cnt;
    logic [CW-1:0]    total, seg;
    logic [CW-1:0]    seg_len, t_meas, div_calc;
    logic [2:0]       edge_cnt;
    logic [DIV_W-1:0] cand;
    logic             timeout, tol_bad, load_div;

    // Synchronizer plus registered edge detector. The pin-to-flag latency is
    // the same for every edge, so measured intervals are exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
            fall_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_sync <= rx_s1;
            rx_prev <= rx_sync;
            fall_q  <= rx_prev & ~rx_sync;
            rise_q  <= ~rx_prev & rx_sync;
        end
    end

    assign edge_q = fall_q | rise_q;

    // The registers hold (cycles since the last event - 1). The +1 terms give
    // the interval that ends in the current cycle.
    assign seg_len  = seg + CW'(1);
    assign t_meas   = total + CW'(1);
    assign div_calc = (t_meas + CW'(4)) >> 3;
    assign timeout  = seg_len > SEG_LIM;

`ifdef UART_AUTOBAUD_TOL_CHECK_EN
    logic [CW-1:0] l0, seg_diff;
    logic          first_seg;

    assign first_seg = (state == S_MEASURE) && (edge_cnt == 3'd0);
    assign seg_diff  = (seg_len >= l0) ? (seg_len - l0) : (l0 - seg_len);
    assign tol_bad   = !first_seg && (seg_diff > (l0 >> 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l0 <= '0;
        end else if (first_seg && edge_q) begin
            l0 <= seg_len;
        end
    end
`else
    assign tol_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        load_div = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_ARM;
            end
            S_ARM: begin
                busy = 1'b1;
                if (rx_sync && (idle_cnt == IDLE_LAST)) state_nx = S_WAIT_START;
            end
            S_WAIT_START: begin
                busy = 1'b1;
                if (fall_q) state_nx = S_MEASURE;
            end
            S_MEASURE: begin
                busy = 1'b1;
                // Timeout takes priority over an edge in the same cycle.
                if (timeout) begin
                    state_nx = S_ERR;
                end else if (edge_q) begin
                    if (tol_bad) begin
                        state_nx = S_ERR;
                    end else if (edge_cnt == 3'd7) begin
                        if ((div_calc < MIN_C) || (t_meas > T_LIM)) state_nx = S_ERR;
                        else                                        state_nx = S_STOP;
                    end
                end
            end
            S_STOP: begin
                busy = 1'b1;
                if (timeout) begin
                    state_nx = S_ERR;
                end else if (rise_q) begin
                    if (tol_bad) begin
                        state_nx = S_ERR;
                    end else begin
                        state_nx = S_DONE;
                        load_div = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            S_ERR: begin
                err      = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Total stops counting at falling edge #5, so it cannot wrap. Each segment
    // is bounded by the timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            total    <= '0;
            seg      <= '0;
            edge_cnt <= '0;
            cand     <= '0;
        end else begin
            if ((state == S_ARM) && rx_sync) idle_cnt <= idle_cnt + IW'(1);
            else                             idle_cnt <= '0;

            case (state)
                S_WAIT_START: begin
                    total    <= '0;
                    seg      <= '0;
                    edge_cnt <= '0;
                end
                S_MEASURE: begin
                    total <= t_meas;
                    seg   <= edge_q ? '0 : seg_len;
                    if (edge_q) begin
                        edge_cnt <= edge_cnt + 3'd1;
                        if (edge_cnt == 3'd7) cand <= div_calc[DIV_W-1:0];
                    end
                end
                S_STOP: begin
                    seg <= edge_q ? '0 : seg_len;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div    <= DIV_W'(DEF_DIV);
            locked <= 1'b0;
        end else if (load_div) begin
            div    <= cand;
            locked <= 1'b1;
        end
    end

    assign half_div = div >> 1;

endmodule

// File: tb/tb_uart_autobaud.sv
module tb_uart_autobaud;

    localparam int DIV_W    = 16;
    localparam int DEF_DIV  = 434;
    localparam int MIN_DIV  = 16;
    localparam int MAX_DIV  = 5208;   // keeps the timeout case short; 8*MAX is hit exactly by the 9600 frame
    localparam int IDLE_CYC = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx = 1'b1;
    logic             start = 1'b0;
    logic [DIV_W-1:0] div, half_div;
    logic             busy, locked, done, err;

    always #5 clk = ~clk;

    uart_autobaud #(
        .DIV_W   (DIV_W),
        .DEF_DIV (DEF_DIV),
        .MIN_DIV (MIN_DIV),
        .MAX_DIV (MAX_DIV),
        .IDLE_CYC(IDLE_CYC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (rx),
        .start   (start),
        .div     (div),
        .half_div(half_div),
        .busy    (busy),
        .locked  (locked),
        .done    (done),
        .err     (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference state
    int exp_div    = DEF_DIV;
    bit exp_locked = 1'b0;

    // bit lengths of the frame: start, d0..d7, stop
    int fr_len[10];

    int               n_done, n_err, busy_bad;
    logic [DIV_W-1:0] div_at_done, half_at_done;
    bit               tx_fin;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference outcome of one frame. The segments are the nine bits from start
    // to d7. T is the span of the first eight bits.
    function automatic bit model_frame(output int d);
        int t;
        bit ok;
        t  = 0;
        ok = 1'b1;
        for (int i = 0; i < 9; i++) if (fr_len[i] > 2 * MAX_DIV) ok = 1'b0;
        for (int i = 0; i < 8; i++) t += fr_len[i];
        d = (t + 4) / 8;
        if (d < MIN_DIV || t > 8 * MAX_DIV) ok = 1'b0;
`ifdef UART_AUTOBAUD_TOL_CHECK_EN
        for (int i = 1; i < 9; i++) begin
            int diff;
            diff = fr_len[i] - fr_len[0];
            if (diff < 0) diff = -diff;
            if (diff > fr_len[0] / 4) ok = 1'b0;
        end
`endif
        return ok;
    endfunction

    task automatic set_all(input int v);
        for (int i = 0; i < 9; i++) fr_len[i] = v;
        fr_len[9] = 8;
    endtask

    task automatic send_frame();
        logic [9:0] pat;
        pat = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = pat[i];
            repeat (fr_len[i]) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic watch(input int budget);
        int post;
        post     = 0;
        n_done   = 0;
        n_err    = 0;
        busy_bad = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                n_done++;
                div_at_done  = div;
                half_at_done = half_div;
            end
            if (err) n_err++;
            if ((done || err) && busy) busy_bad++;
            if (n_done + n_err > 0) post++;
            if (tx_fin && post >= 4) break;
        end
    endtask

    task automatic pulse_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".busy_rise"}, busy, 1);
        repeat (80) @(negedge clk);
    endtask

    task automatic run_frame(input string tag);
        int budget, d;
        bit ok;
        budget = 64;
        for (int i = 0; i < 10; i++) budget += fr_len[i];
        pulse_start(tag);
        tx_fin = 1'b0;
        fork
            begin
                send_frame();
                tx_fin = 1'b1;
            end
            watch(budget);
        join
        ok = model_frame(d);
        if (ok) begin
            exp_div    = d;
            exp_locked = 1'b1;
        end
        check({tag, ".done"}, n_done, ok ? 1 : 0);
        check({tag, ".err"}, n_err, ok ? 0 : 1);
        check({tag, ".busy_at_pulse"}, busy_bad, 0);
        if (ok) begin
            check({tag, ".div_at_done"}, div_at_done, exp_div);
            check({tag, ".half_at_done"}, half_at_done, exp_div / 2);
        end
        check({tag, ".div"}, div, exp_div);
        check({tag, ".half_div"}, half_div, exp_div / 2);
        check({tag, ".locked"}, locked, exp_locked);
        check({tag, ".busy"}, busy, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".div"}, div, DEF_DIV);
        check({tag, ".half_div"}, half_div, DEF_DIV / 2);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".locked"}, locked, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".err"}, err, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "time limit reached");
    end

    initial begin
        int elapsed, d;
        bit got_err, busy_at, ok;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");

        set_all(434);
        run_frame("b115200");

        set_all(5208);
        run_frame("b9600");

        set_all(10);
        run_frame("too_fast");

        fr_len = '{16, 16, 16, 16, 15, 15, 15, 15, 16, 8};
        run_frame("min_edge_ok");
        fr_len = '{16, 16, 16, 15, 15, 15, 15, 15, 16, 8};
        run_frame("min_edge_low");

        set_all(434);
        fr_len[4] = 651;
        run_frame("d3_stretch");

        for (int k = 0; k < 6; k++) begin
            int base, spread;
            base   = int'($urandom_range(10, 48));
            spread = ($urandom_range(0, 1) != 0) ? base / 6 : base / 2;
            for (int i = 0; i < 9; i++)
                fr_len[i] = base + int'($urandom_range(0, 2 * spread)) - spread;
            fr_len[9] = 8;
            run_frame($sformatf("rand%0d", k));
        end

        // rx stays high after falling edge #2 completes its bit
        pulse_start("tmo");
        rx = 1'b0; repeat (434) @(negedge clk);
        rx = 1'b1; repeat (434) @(negedge clk);
        rx = 1'b0; repeat (434) @(negedge clk);
        rx = 1'b1;
        elapsed = 0;
        got_err = 1'b0;
        busy_at = 1'b1;
        while (!got_err && elapsed < 2 * MAX_DIV + 100) begin
            @(negedge clk);
            elapsed++;
            if (err) begin
                got_err = 1'b1;
                busy_at = busy;
            end
        end
        set_all(434);
        fr_len[3] = 2 * MAX_DIV + 1;
        ok = model_frame(d);
        check("tmo.err", got_err, ok ? 0 : 1);
        check("tmo.window", (elapsed > 2 * MAX_DIV) && (elapsed <= 2 * MAX_DIV + 8), 1);
        check("tmo.busy", busy_at, 0);
        check("tmo.div", div, exp_div);
        check("tmo.locked", locked, exp_locked);

        // reset in the middle of a measurement
        pulse_start("rst_mid");
        rx = 1'b0; repeat (434) @(negedge clk);
        rx = 1'b1; repeat (434) @(negedge clk);
        rx = 1'b0; repeat (200) @(negedge clk);
        check("rst_mid.busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        exp_div    = DEF_DIV;
        exp_locked = 1'b0;
        check_reset_vals("rst_mid");
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        set_all(434);
        run_frame("relock");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
